// File: rtl/sd_read_sequencer_pkg.sv
// Shared encodings and constants for the SD single-block read sequencer.
package sd_read_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD,
    S_RESP_WAIT,
    S_RESP,
    S_TOKEN,
    S_DATA,
    S_CRC,
    S_TAIL,
    S_FIN
  } state_e;

  // Command / data framing bytes
  localparam logic [7:0] CMD17_OPCODE = 8'h51;
  localparam logic [7:0] DATA_TOKEN   = 8'hFE;
  localparam logic [7:0] STUFF_BYTE   = 8'hFF;

  // Completion codes reported on errCode
  localparam logic [1:0] ERR_OK            = 2'b00;
  localparam logic [1:0] ERR_R1_TIMEOUT    = 2'b01;
  localparam logic [1:0] ERR_R1_NONZERO    = 2'b10;
  localparam logic [1:0] ERR_TOKEN_TIMEOUT = 2'b11;

  // Fixed phase lengths in bit-times
  localparam int FRAME_W      = 48;
  localparam int R1_TAIL_BITS = 7;
  localparam int CRC_BITS     = 16;
  localparam int TAIL_BITS    = 8;

  // The shared counter counts down to zero inside a state, so a state that
  // lasts N cycles is entered with N-1 (never below zero).
  function automatic logic [15:0] cnt_load(input logic [15:0] cycles);
    return (cycles == 16'd0) ? 16'd0 : cycles - 16'd1;
  endfunction

endpackage

// File: rtl/sd_cmd_shifter.sv
// Parallel-load, MSB-first serialiser for the 48-bit SD command frame.
// The output bit is the MSB flop itself, and vacated bits fill with 1 so the
// line idles high once the frame has been shifted out.
module sd_cmd_shifter #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         dout,
  output logic         empty
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next shift-register contents and remaining-bit count
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = din;
      cnt_d = CW'(W);
    end else if (shift && cnt_q != '0) begin
      sr_d  = {sr_q[W-2:0], 1'b1};
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Register stage; reset leaves the line idling high
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '1;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = sr_q[W-1];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/sd_read_sequencer.sv
// SPI-mode SD CMD17 sequencer: sends the command, waits for R1 and the data
// token, hands the payload to an external block receiver, skips the CRC and
// closes with eight idle clocks before reporting completion.
module sd_read_sequencer
  import sd_read_sequencer_pkg::*;
#(
  parameter logic [7:0]  RESP_TIMEOUT  = 8'd64,
  parameter logic [15:0] TOKEN_TIMEOUT = 16'd50000,
  parameter logic        BYTE_ADDR     = 1'b0
) (
  input  logic        clk400,
  input  logic        reset,
  input  logic        readReq,
  input  logic [31:0] blockAddr,
  input  logic        SDin,
  input  logic        rxDone,
  output logic        SDout,
  output logic        sdCS_n,
  output logic        rxEnable,
  output logic        rxAbort,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  errCode
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [6:0]  r1_q, r1_d;
  logic [7:0]  r1_full;
  logic [1:0]  err_q, err_d;
  logic        cs_n_q, cs_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        rx_en_q, rx_en_d;
  logic        rx_abort_q, rx_abort_d;

  logic [31:0] cmd_arg;
  logic [47:0] cmd_frame;
  logic        sh_load, sh_shift, sh_empty, sh_dout;

  // Complete R1 byte as seen on the final RESP cycle
  assign r1_full = {r1_q, SDin};

  // Shifter only advances while the command is on the wire
  assign sh_shift = (state_q == S_CMD) && !sh_empty;

  // Next-state, counter reload and next registered-output values
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == 16'd0) ? 16'd0 : cnt_q - 16'd1;
    addr_d     = addr_q;
    r1_d       = r1_q;
    err_d      = err_q;
    rx_en_d    = 1'b0;
    rx_abort_d = 1'b0;
    sh_load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (readReq) begin
          addr_d  = blockAddr;
          err_d   = ERR_OK;
          sh_load = 1'b1;
          state_d = S_CMD;
          cnt_d   = cnt_load(16'(FRAME_W));
        end
      end
      S_CMD: begin
        if (cnt_q == 16'd0) begin
          state_d = S_RESP_WAIT;
          cnt_d   = cnt_load({8'h00, RESP_TIMEOUT});
        end
      end
      S_RESP_WAIT: begin
        if (!SDin) begin
          // R1 start bit doubles as its MSB
          r1_d    = {6'd0, SDin};
          state_d = S_RESP;
          cnt_d   = cnt_load(16'(R1_TAIL_BITS));
        end else if (cnt_q == 16'd0) begin
          err_d   = ERR_R1_TIMEOUT;
          state_d = S_TAIL;
          cnt_d   = cnt_load(16'(TAIL_BITS));
        end
      end
      S_RESP: begin
        r1_d = r1_full[6:0];
        if (cnt_q == 16'd0) begin
          if (r1_full == 8'h00) begin
            rx_en_d = 1'b1;
            state_d = S_TOKEN;
            cnt_d   = cnt_load(TOKEN_TIMEOUT);
          end else begin
            err_d   = ERR_R1_NONZERO;
            state_d = S_TAIL;
            cnt_d   = cnt_load(16'(TAIL_BITS));
          end
        end
      end
      S_TOKEN: begin
        // Leading ones of the token are indistinguishable from idle; the
        // trailing zero is what marks the start of data.
        if (SDin == DATA_TOKEN[0]) begin
          state_d = S_DATA;
          cnt_d   = 16'd0;
        end else if (cnt_q == 16'd0) begin
          rx_abort_d = 1'b1;
          err_d      = ERR_TOKEN_TIMEOUT;
          state_d    = S_TAIL;
          cnt_d      = cnt_load(16'(TAIL_BITS));
        end
      end
      S_DATA: begin
        if (rxDone) begin
          state_d = S_CRC;
          cnt_d   = cnt_load(16'(CRC_BITS));
        end
      end
      S_CRC: begin
        if (cnt_q == 16'd0) begin
          err_d   = ERR_OK;
          state_d = S_TAIL;
          cnt_d   = cnt_load(16'(TAIL_BITS));
        end
      end
      S_TAIL: begin
        if (cnt_q == 16'd0) begin
          state_d = S_FIN;
          cnt_d   = 16'd0;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
      end
    endcase

    cmd_arg   = BYTE_ADDR ? {addr_d[22:0], 9'd0} : addr_d;
    cmd_frame = {CMD17_OPCODE, cmd_arg, STUFF_BYTE};

    // Outputs are decoded from the state being entered so they line up with it
    cs_n_d  = !(state_d inside {S_CMD, S_RESP_WAIT, S_RESP, S_TOKEN, S_DATA, S_CRC});
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_FIN);
    error_d = (state_d == S_FIN) && (err_d != ERR_OK);
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk400) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      addr_q     <= 32'd0;
      r1_q       <= 7'd0;
      err_q      <= ERR_OK;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      rx_abort_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      r1_q       <= r1_d;
      err_q      <= err_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rx_en_q    <= rx_en_d;
      rx_abort_q <= rx_abort_d;
    end
  end

  sd_cmd_shifter #(
    .W(FRAME_W)
  ) u_shifter (
    .clk  (clk400),
    .reset(reset),
    .load (sh_load),
    .shift(sh_shift),
    .din  (cmd_frame),
    .dout (sh_dout),
    .empty(sh_empty)
  );

  assign SDout    = sh_dout;
  assign sdCS_n   = cs_n_q;
  assign rxEnable = rx_en_q;
  assign rxAbort  = rx_abort_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign errCode  = err_q;

endmodule

// File: tb/tb_sd_read_sequencer.sv
// Bench: two sequencers (block and byte addressing) share one card model.
// Expected completions are queued at request time; a negedge monitor
// reassembles each transaction from the pins and checks it on done.
module tb_sd_read_sequencer;

  logic        clk400 = 1'b0;
  logic        reset, readReq, SDin, rxDone;
  logic [31:0] blockAddr;
  logic [1:0]  so_w, cs_w, en_w, ab_w, bsy_w, dn_w, er_w;
  logic [1:0]  code0, code1;

  always #5 clk400 = ~clk400;

  sd_read_sequencer #(.BYTE_ADDR(1'b0)) dut0 (
    .clk400(clk400), .reset(reset), .readReq(readReq), .blockAddr(blockAddr),
    .SDin(SDin), .rxDone(rxDone), .SDout(so_w[0]), .sdCS_n(cs_w[0]),
    .rxEnable(en_w[0]), .rxAbort(ab_w[0]), .busy(bsy_w[0]), .done(dn_w[0]),
    .error(er_w[0]), .errCode(code0));

  sd_read_sequencer #(.BYTE_ADDR(1'b1)) dut1 (
    .clk400(clk400), .reset(reset), .readReq(readReq), .blockAddr(blockAddr),
    .SDin(SDin), .rxDone(rxDone), .SDout(so_w[1]), .sdCS_n(cs_w[1]),
    .rxEnable(en_w[1]), .rxAbort(ab_w[1]), .busy(bsy_w[1]), .done(dn_w[1]),
    .error(er_w[1]), .errCode(code1));

  typedef struct {
    logic [47:0] frame;
    logic [1:0]  code;
    logic        err;
    int          n_en;
    int          n_ab;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Monitor-owned bookkeeping, one slot per instance
  logic        prev_cs[2] = '{1'b1, 1'b1};
  int          cap_n[2], n_en[2], n_ab[2], tail_n[2], stray[2];
  logic [47:0] facc[2];
  bit          chk_busy[2];
  int          done_seen[2] = '{0, 0};
  int          frames_seen[2] = '{0, 0};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [47:0] ref_frame(input logic [31:0] a, input bit byte_mode);
    logic [31:0] arg;
    arg = byte_mode ? a * 32'd512 : a;
    return {8'h51, arg, 8'hFF};
  endfunction

  // Card behaviour: d1 idle ones, R1 byte, d2 idle ones, FE token.
  // R1 window is 64 bit-times, token window is 50000 bit-times of ones.
  function automatic exp_t ref_txn(input logic [31:0] a, input bit byte_mode,
                                   input int d1, input logic [7:0] r1, input int d2);
    exp_t e;
    e.frame = ref_frame(a, byte_mode);
    e.n_en  = 0;
    e.n_ab  = 0;
    if (d1 >= 64)            e.code = 2'b01;
    else if (r1 != 8'h00)    e.code = 2'b10;
    else if (d2 + 7 >= 50000) begin
      e.code = 2'b11; e.n_en = 1; e.n_ab = 1;
    end else begin
      e.code = 2'b00; e.n_en = 1;
    end
    e.err = (e.code != 2'b00);
    return e;
  endfunction

  // ---------------- monitor ----------------
  task automatic mon(input int i, input logic cs, input logic so, input logic en,
                     input logic ab, input logic bsy, input logic dn, input logic er,
                     input logic [1:0] code);
    exp_t e;
    if (chk_busy[i]) begin
      chk($sformatf("busy_after_done[%0d]", i), 64'(bsy), 64'd0);
      chk_busy[i] = 1'b0;
    end
    if (cs === 1'b0 && prev_cs[i] === 1'b1) begin
      frames_seen[i]++;
      cap_n[i] = 0; n_en[i] = 0; n_ab[i] = 0; tail_n[i] = 0; stray[i] = 0;
      facc[i] = '0;
    end
    if (cs === 1'b0 && cap_n[i] < 48) begin
      facc[i] = {facc[i][46:0], so};
      cap_n[i]++;
    end else if (so === 1'b0) begin
      stray[i]++;
    end
    if (en === 1'b1) n_en[i]++;
    if (ab === 1'b1) n_ab[i]++;
    if (cs === 1'b1 && bsy === 1'b1 && dn === 1'b0) tail_n[i]++;
    if (dn === 1'b1) begin
      done_seen[i]++;
      if ((i == 0 ? q0.size() : q1.size()) == 0) begin
        chk($sformatf("unexpected_done[%0d]", i), 64'd1, 64'd0);
      end else begin
        e = (i == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("frame[%0d]", i),     64'(facc[i]),   64'(e.frame));
        chk($sformatf("errCode[%0d]", i),   64'(code),      64'(e.code));
        chk($sformatf("error[%0d]", i),     64'(er),        64'(e.err));
        chk($sformatf("rxEnable_n[%0d]", i), 64'(n_en[i]),  64'(e.n_en));
        chk($sformatf("rxAbort_n[%0d]", i), 64'(n_ab[i]),   64'(e.n_ab));
        chk($sformatf("tail_len[%0d]", i),  64'(tail_n[i]), 64'd8);
        chk($sformatf("sdout_stray[%0d]", i), 64'(stray[i]), 64'd0);
        chk_busy[i] = 1'b1;
      end
    end
    prev_cs[i] = cs;
  endtask

  always @(negedge clk400) begin
    mon(0, cs_w[0], so_w[0], en_w[0], ab_w[0], bsy_w[0], dn_w[0], er_w[0], code0);
    mon(1, cs_w[1], so_w[1], en_w[1], ab_w[1], bsy_w[1], dn_w[1], er_w[1], code1);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk400);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int b = 7; b >= 0; b--) begin
      SDin = v[b];
      tick();
    end
    SDin = 1'b1;
  endtask

  task automatic card_resp(input int d1, input logic [7:0] r1, input int d2);
    SDin = 1'b1;
    repeat (d1) tick();
    send_byte(r1);
    repeat (d2) tick();
    send_byte(8'hFE);
  endtask

  task automatic check_idle(input string tag, input logic exp_abort);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_cs_n[%0d]", tag, i),  64'(cs_w[i]),  64'd1);
      chk($sformatf("%s_sdout[%0d]", tag, i), 64'(so_w[i]),  64'd1);
      chk($sformatf("%s_busy[%0d]", tag, i),  64'(bsy_w[i]), 64'd0);
      chk($sformatf("%s_done[%0d]", tag, i),  64'(dn_w[i]),  64'd0);
      chk($sformatf("%s_error[%0d]", tag, i), 64'(er_w[i]),  64'd0);
      chk($sformatf("%s_rxen[%0d]", tag, i),  64'(en_w[i]),  64'd0);
      chk($sformatf("%s_abort[%0d]", tag, i), 64'(ab_w[i]),  64'(exp_abort));
    end
    chk({tag, "_code[0]"}, 64'(code0), 64'd0);
    chk({tag, "_code[1]"}, 64'(code1), 64'd0);
  endtask

  task automatic run_txn(input logic [31:0] a, input int d1, input logic [7:0] r1,
                         input int d2, input int d3);
    int b0, b1;
    q0.push_back(ref_txn(a, 1'b0, d1, r1, d2));
    q1.push_back(ref_txn(a, 1'b1, d1, r1, d2));
    b0 = done_seen[0];
    b1 = done_seen[1];
    blockAddr = a;
    readReq   = 1'b1;
    tick();
    readReq   = 1'b0;
    blockAddr = $urandom;
    repeat (48) tick();
    card_resp(d1, r1, d2);
    repeat (d3) begin
      SDin = 1'($urandom_range(0, 1));
      tick();
    end
    SDin   = 1'b1;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    for (int k = 0; k < 300 && (done_seen[0] <= b0 || done_seen[1] <= b1); k++) tick();
    chk("done_arrive[0]", 64'(done_seen[0] - b0), 64'd1);
    chk("done_arrive[1]", 64'(done_seen[1] - b1), 64'd1);
    repeat (2) tick();
  endtask

  task automatic reset_mid_data();
    int f0, f1, d0, dd1;
    f0 = frames_seen[0]; f1 = frames_seen[1];
    d0 = done_seen[0];   dd1 = done_seen[1];
    blockAddr = 32'h0000_ABCD;
    readReq   = 1'b1;
    tick();
    readReq = 1'b0;
    repeat (5) tick();
    readReq   = 1'b1;
    blockAddr = 32'h5555_5555;
    tick();
    readReq = 1'b0;
    repeat (42) tick();
    card_resp(2, 8'h00, 3);
    repeat (5) tick();
    readReq = 1'b1;
    tick();
    readReq = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check_idle("rst_mid", 1'b1);
    reset = 1'b0;
    tick();
    check_idle("rst_mid_rel", 1'b0);
    repeat (20) tick();
    chk("rst_frames[0]", 64'(frames_seen[0] - f0), 64'd1);
    chk("rst_frames[1]", 64'(frames_seen[1] - f1), 64'd1);
    chk("rst_no_done[0]", 64'(done_seen[0] - d0), 64'd0);
    chk("rst_no_done[1]", 64'(done_seen[1] - dd1), 64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    readReq   = 1'b0;
    SDin      = 1'b1;
    rxDone    = 1'b0;
    blockAddr = 32'd0;
    repeat (3) tick();
    check_idle("reset", 1'b1);
    reset = 1'b0;
    tick();
    check_idle("post_reset", 1'b0);

    // Nominal read, token and payload timing from the bring-up capture
    run_txn(32'h0000_1234, 3, 8'h00, 10, 4096);
    // Byte addressing of block 1 (checked on the byte-mode instance)
    run_txn(32'h0000_0001, 1, 8'h00, 2, 5);
    // Card silent: R1 window expires, late R1 must be ignored
    run_txn(32'h0000_0042, 64, 8'h00, 0, 0);
    // Latest R1 that is still inside the window
    run_txn(32'h0000_0043, 63, 8'h00, 4, 3);
    // Illegal-command style R1
    run_txn(32'h0000_0044, 2, 8'h04, 0, 0);
    // Token arrives one bit-time too late: timeout with abort
    run_txn(32'h0000_0045, 0, 8'h00, 50000 - 7, 2);
    // Reset while receiving data, with extra requests while busy
    reset_mid_data();

    for (int n = 0; n < 12; n++) begin
      int d1, d2, d3;
      logic [7:0] r1;
      d1 = ($urandom_range(0, 5) == 0) ? $urandom_range(62, 66) : $urandom_range(0, 12);
      r1 = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 127)) : 8'h00;
      d2 = $urandom_range(0, 20);
      d3 = $urandom_range(0, 40);
      run_txn($urandom, d1, r1, d2, d3);
    end

    repeat (5) tick();
    chk("leftover[0]", 64'(q0.size()), 64'd0);
    chk("leftover[1]", 64'(q1.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_read_sequencer.md
SD_READ_SEQUENCER -- requirements
Module: sd_read_sequencer

Interface
REQ-001 The block SHALL take these parameters: RESP_TIMEOUT, 8'd64, maximum bit-times to wait for the R1 start bit.
REQ-002 TOKEN_TIMEOUT, 16'd50000, maximum bit-times to wait for the data start token.
REQ-003 BYTE_ADDR, 1'b0, when 1 the CMD17 argument is blockAddr<<9, otherwise blockAddr.
REQ-004 Ports SHALL be:
- clk400  in  1  single clock; SPI bit clock.
- reset  in  1  synchronous, active-high reset.
- readReq  in  1  start one 512-byte block read.
- blockAddr  in  32  block number.
- SDin  in  1  MISO.
- rxDone  in  1  block receiver done.
- SDout  out  1  MOSI.
- sdCS_n  out  1  card select, active low.
- rxEnable  out  1  one-cycle start pulse to the block receiver.
- rxAbort  out  1  one-cycle reset pulse to the block receiver.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  completion was a failure, valid with done.
- errCode  out  2  00 ok, 01 R1 timeout, 10 R1 nonzero, 11 token timeout.
REQ-005 Every output SHALL be registered; the card samples SDout on the rising edge of clk400.

Function
REQ-006 States SHALL be IDLE, CMD, RESP_WAIT, RESP, TOKEN, DATA, CRC, TAIL, FIN.
REQ-007 IDLE behaviour:
- outputs are sdCS_n=1, SDout=1, busy=0.
- readReq=1 latches blockAddr, sets busy=1 and enters CMD on the next edge.
REQ-008 readReq asserted while busy=1 SHALL be ignored; no queueing.
REQ-009 CMD SHALL hold sdCS_n=0 and shift the 48-bit frame {8'h51, arg[31:0], 8'hFF} MSB first, one bit per cycle, exactly 48 cycles, then enter RESP_WAIT with SDout=1.
REQ-010 RESP_WAIT behaviour:
- SDin=0 captures bit 7 of R1 and enters RESP.
- after RESP_TIMEOUT cycles with SDin=1, enter TAIL with errCode=01.
REQ-011 RESP SHALL shift 7 further bits, MSB first.
- R1==8'h00 enters TOKEN and pulses rxEnable for exactly one cycle.
- any other R1 enters TAIL with errCode=10.
REQ-012 TOKEN behaviour:
- SDin=0, the 8'hFE token end bit, enters DATA.
- after TOKEN_TIMEOUT cycles with SDin=1, pulse rxAbort for one cycle and enter TAIL with errCode=11.
REQ-013 DATA SHALL wait for rxDone=1 with no timeout, then enter CRC.
REQ-014 CRC SHALL clock and discard exactly 16 bits, then enter TAIL with errCode=00.
REQ-015 TAIL SHALL drive sdCS_n=1 and SDout=1 for exactly 8 cycles, then enter FIN.
REQ-016 FIN SHALL last one cycle:
- done=1, error=(errCode!=00), busy=0 on exit.
- return to IDLE.
REQ-017 errCode SHALL hold its value until the next accepted readReq, which clears it to 00.
REQ-018 The bit and timeout counters SHALL be one shared 16-bit down-counter, loaded on every state entry; it SHALL NOT wrap.
REQ-019 SDout SHALL be 1 in every state except CMD.

Reset
REQ-020 Reset SHALL synchronously force the following on the next edge, regardless of state:
- state=IDLE.
- sdCS_n=1, SDout=1.
- rxEnable=0, done=0, error=0, busy=0, errCode=00.
- counter and latched address cleared.
- rxAbort=1 for that one cycle.
REQ-021 Reset in mid-transaction SHALL produce no done pulse.

Structure
REQ-022 A shared package SHALL hold:
- the state encoding.
- CMD17 opcode 8'h51, token 8'hFE, CRC/stuff byte 8'hFF.
- the errCode constants.
REQ-023 A single sub-module, sd_cmd_shifter, SHALL perform 48-bit parallel-load MSB-first serialisation with a load strobe and an empty flag.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- readReq, blockAddr=32'h1234, BYTE_ADDR=0; card gives R1=00 after 3 idle bits, token after 10, rxDone after 4096 -> MOSI frame 51 00 00 12 34 FF; rxEnable one cycle; done with error=0; sdCS_n high 8 cycles before done.
- BYTE_ADDR=1, blockAddr=1 -> argument 32'h00000200.
- SDin held 1 after CMD -> after 64 cycles done, errCode=01, no rxEnable.
- R1=8'h04 -> done, errCode=10, no rxEnable.
- R1 ok, token never sent -> after 50000 cycles rxAbort pulses once, done, errCode=11.
- Reset asserted during DATA, and readReq pulsed while busy -> idle outputs next edge, no done; second request ignored, exactly one frame sent.
